// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl
// Sequences one memory micro-op at a time from the execute stage onto the
// dcache request port. It issues the request and reissues it after a nack.
// A kill or exception return aborts the request. The controller returns one
// extended load result, or one exception code, per transaction.
//
// Ports
//   clk_i, rstn_i            clock, synchronous active-low reset
//   valid_i, kill_i,
//   csr_eret_i               micro-op present / pipeline flush / exception return
//   is_store_i, funct3_i,
//   addr_i, data_i, rd_i     micro-op fields (latched when the op is accepted)
//   dmem_req_ready_i         dcache accepts the request
//   dmem_resp_*_i            dcache response, nack and load data
//   dmem_xcpt_*_i            dcache misaligned / page-fault exceptions
//   dmem_req_*_o             dcache request (valid, cmd, addr, op type, data, tag, kill)
//   ready_o                  one-cycle completion pulse
//   data_o, rd_o, xcpt_o     load result, destination register, exception code
//   err_o                    sticky: nack retry limit exceeded
//   lock_o                   pipeline stall request
module dmem_req_ctrl #(
    parameter int XLEN       = 64,
    parameter int NACK_LIMIT = 15
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    input  logic            kill_i,
    input  logic            csr_eret_i,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [4:0]      rd_i,
    input  logic            dmem_req_ready_i,
    input  logic            dmem_resp_valid_i,
    input  logic            dmem_resp_nack_i,
    input  logic [XLEN-1:0] dmem_resp_data_i,
    input  logic            dmem_xcpt_ma_ld_i,
    input  logic            dmem_xcpt_ma_st_i,
    input  logic            dmem_xcpt_pf_ld_i,
    input  logic            dmem_xcpt_pf_st_i,
    output logic            dmem_req_valid_o,
    output logic [4:0]      dmem_req_cmd_o,
    output logic [XLEN-1:0] dmem_req_addr_o,
    output logic [2:0]      dmem_op_type_o,
    output logic [XLEN-1:0] dmem_req_data_o,
    output logic [7:0]      dmem_req_tag_o,
    output logic            dmem_req_kill_o,
    output logic            ready_o,
    output logic [XLEN-1:0] data_o,
    output logic [4:0]      rd_o,
    output logic [1:0]      xcpt_o,
    output logic            err_o,
    output logic            lock_o
);

    localparam int CW = $clog2(NACK_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_retry;
    logic            r_is_store;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_data;
    logic [1:0]      r_xcpt;
    logic            r_err;

    logic            w_flush;
    logic            w_accept;
    logic            w_wait_live;
    logic            w_nack;
    logic            w_nack_limit;
    logic            w_xcpt_any;
    logic            w_xcpt_hit;
    logic            w_resp_hit;
    logic [XLEN-1:0] w_ext_data;

    // Byte, half and word come from the low bits of the right-aligned response.
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3)
            3'd0:    extend = {{(XLEN-8){d[7]}},   d[7:0]};
            3'd1:    extend = {{(XLEN-16){d[15]}}, d[15:0]};
            3'd2:    extend = {{(XLEN-32){d[31]}}, d[31:0]};
            3'd4:    extend = {{(XLEN-8){1'b0}},   d[7:0]};
            3'd5:    extend = {{(XLEN-16){1'b0}},  d[15:0]};
            3'd6:    extend = {{(XLEN-32){1'b0}},  d[31:0]};
            default: extend = d;
        endcase
    endfunction

    assign w_flush      = kill_i | csr_eret_i;
    assign w_accept     = (r_state == S_IDLE) & valid_i & ~w_flush;
    // A response in WAIT is dropped when a flush arrives in the same cycle.
    assign w_wait_live  = (r_state == S_WAIT) & ~w_flush;
    assign w_nack       = w_wait_live & dmem_resp_nack_i;
    assign w_nack_limit = w_nack & (r_retry == CW'(NACK_LIMIT));
    assign w_xcpt_any   = dmem_xcpt_ma_ld_i | dmem_xcpt_ma_st_i |
                          dmem_xcpt_pf_ld_i | dmem_xcpt_pf_st_i;
    assign w_xcpt_hit   = w_wait_live & ~dmem_resp_nack_i & w_xcpt_any;
    assign w_resp_hit   = w_wait_live & ~dmem_resp_nack_i & ~w_xcpt_any & dmem_resp_valid_i;
    assign w_ext_data   = extend(r_funct3, dmem_resp_data_i);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so that every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_REQ;
            S_REQ: begin
                if (w_flush)               w_next = S_IDLE;
                else if (dmem_req_ready_i) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_flush)                 w_next = S_IDLE;
                else if (dmem_resp_nack_i)   w_next = w_nack_limit ? S_DONE : S_REQ;
                else if (w_xcpt_any)         w_next = S_DONE;
                else if (dmem_resp_valid_i)  w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request fields, retry counter and result registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_retry    <= '0;
            r_is_store <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_data     <= '0;
            r_xcpt     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_retry    <= '0;
                r_is_store <= is_store_i;
                r_funct3   <= funct3_i;
                r_addr     <= addr_i;
                r_wdata    <= data_i;
                r_rd       <= rd_i;
                r_data     <= '0;
                r_xcpt     <= '0;
            end
            if (w_nack_limit) begin
                r_err  <= 1'b1;
                r_xcpt <= '0;
            end else if (w_nack) begin
                r_retry <= r_retry + CW'(1);
            end
            // A page fault has priority over a misaligned access.
            if (w_xcpt_hit) begin
                r_xcpt <= (dmem_xcpt_pf_ld_i | dmem_xcpt_pf_st_i) ? 2'd2 : 2'd1;
            end
            if (w_resp_hit) begin
                r_data <= r_is_store ? '0 : w_ext_data;
            end
        end
    end

    // Outputs decoded from the state.
    always_comb begin
        dmem_req_valid_o = (r_state == S_REQ);
        dmem_req_kill_o  = ((r_state == S_REQ) | (r_state == S_WAIT)) & w_flush;
        ready_o          = (r_state == S_DONE) & ~w_flush;
        // lock_o drops in DONE, so the pipeline advances on the ready_o cycle.
        lock_o           = ((r_state == S_IDLE) & valid_i) |
                           (r_state == S_REQ) | (r_state == S_WAIT);
    end

    assign dmem_req_cmd_o  = {4'b0000, r_is_store};
    assign dmem_req_addr_o = r_addr;
    assign dmem_op_type_o  = r_funct3;
    assign dmem_req_data_o = r_wdata;
    assign dmem_req_tag_o  = {3'b000, r_rd};
    assign data_o          = r_data;
    assign rd_o            = r_rd;
    assign xcpt_o          = r_xcpt;
    assign err_o           = r_err;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed testbench for dmem_req_ctrl. It drives inputs 2 ns after each rising
// edge and samples outputs after that point. Expected values are worked out by hand.
module tb_dmem_req_ctrl;

    logic        clk_i;
    logic        rstn_i;
    logic        valid_i;
    logic        kill_i;
    logic        csr_eret_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i;
    logic [63:0] data_i;
    logic [4:0]  rd_i;
    logic        dmem_req_ready_i;
    logic        dmem_resp_valid_i;
    logic        dmem_resp_nack_i;
    logic [63:0] dmem_resp_data_i;
    logic        dmem_xcpt_ma_ld_i;
    logic        dmem_xcpt_ma_st_i;
    logic        dmem_xcpt_pf_ld_i;
    logic        dmem_xcpt_pf_st_i;
    logic        dmem_req_valid_o;
    logic [4:0]  dmem_req_cmd_o;
    logic [63:0] dmem_req_addr_o;
    logic [2:0]  dmem_op_type_o;
    logic [63:0] dmem_req_data_o;
    logic [7:0]  dmem_req_tag_o;
    logic        dmem_req_kill_o;
    logic        ready_o;
    logic [63:0] data_o;
    logic [4:0]  rd_o;
    logic [1:0]  xcpt_o;
    logic        err_o;
    logic        lock_o;

    int n_total = 0;
    int n_bad   = 0;

    dmem_req_ctrl #(.XLEN(64), .NACK_LIMIT(15)) dut (
        .clk_i             (clk_i),
        .rstn_i            (rstn_i),
        .valid_i           (valid_i),
        .kill_i            (kill_i),
        .csr_eret_i        (csr_eret_i),
        .is_store_i        (is_store_i),
        .funct3_i          (funct3_i),
        .addr_i            (addr_i),
        .data_i            (data_i),
        .rd_i              (rd_i),
        .dmem_req_ready_i  (dmem_req_ready_i),
        .dmem_resp_valid_i (dmem_resp_valid_i),
        .dmem_resp_nack_i  (dmem_resp_nack_i),
        .dmem_resp_data_i  (dmem_resp_data_i),
        .dmem_xcpt_ma_ld_i (dmem_xcpt_ma_ld_i),
        .dmem_xcpt_ma_st_i (dmem_xcpt_ma_st_i),
        .dmem_xcpt_pf_ld_i (dmem_xcpt_pf_ld_i),
        .dmem_xcpt_pf_st_i (dmem_xcpt_pf_st_i),
        .dmem_req_valid_o  (dmem_req_valid_o),
        .dmem_req_cmd_o    (dmem_req_cmd_o),
        .dmem_req_addr_o   (dmem_req_addr_o),
        .dmem_op_type_o    (dmem_op_type_o),
        .dmem_req_data_o   (dmem_req_data_o),
        .dmem_req_tag_o    (dmem_req_tag_o),
        .dmem_req_kill_o   (dmem_req_kill_o),
        .ready_o           (ready_o),
        .data_o            (data_o),
        .rd_o              (rd_o),
        .xcpt_o            (xcpt_o),
        .err_o             (err_o),
        .lock_o            (lock_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic clear_inputs();
        valid_i = 0; kill_i = 0; csr_eret_i = 0; is_store_i = 0; funct3_i = 0;
        addr_i = 0; data_i = 0; rd_i = 0; dmem_req_ready_i = 0;
        dmem_resp_valid_i = 0; dmem_resp_nack_i = 0; dmem_resp_data_i = 0;
        dmem_xcpt_ma_ld_i = 0; dmem_xcpt_ma_st_i = 0;
        dmem_xcpt_pf_ld_i = 0; dmem_xcpt_pf_st_i = 0;
    endtask

    // Starts a transaction from IDLE with the dcache ready; returns in REQ with valid_i low.
    task automatic start(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [4:0] rd, input logic rdy);
        valid_i = 1; is_store_i = st; funct3_i = f3; addr_i = a; data_i = wd; rd_i = rd;
        dmem_req_ready_i = rdy;
        step();
        valid_i = 0;
    endtask

    // Minimum-latency transaction: valid at cycle 0, ready at 1, response at 2, ready_o at 3.
    task automatic run_xact(input string tag, input logic st, input logic [2:0] f3,
                            input logic [63:0] a, input logic [4:0] rd,
                            input logic [63:0] rdata, input logic [63:0] exp_data);
        valid_i = 1; is_store_i = st; funct3_i = f3; addr_i = a; rd_i = rd;
        dmem_req_ready_i = 1;
        #1 check({tag, ".lock_c0"}, 64'(lock_o), 64'd1);
        step();
        valid_i = 0;
        check({tag, ".req_valid"}, 64'(dmem_req_valid_o), 64'd1);
        check({tag, ".req_addr"}, dmem_req_addr_o, a);
        check({tag, ".req_tag"}, 64'(dmem_req_tag_o), 64'(rd));
        check({tag, ".op_type"}, 64'(dmem_op_type_o), 64'(f3));
        step();
        dmem_req_ready_i = 0;
        check({tag, ".wait_lock"}, 64'(lock_o), 64'd1);
        dmem_resp_valid_i = 1; dmem_resp_data_i = rdata;
        step();
        dmem_resp_valid_i = 0;
        check({tag, ".ready"}, 64'(ready_o), 64'd1);
        check({tag, ".data"}, data_o, exp_data);
        check({tag, ".rd"}, 64'(rd_o), 64'(rd));
        check({tag, ".done_lock"}, 64'(lock_o), 64'd0);
        step();
        check({tag, ".ready_off"}, 64'(ready_o), 64'd0);
    endtask

    initial begin
        clear_inputs();
        rstn_i = 0;
        step();
        step();
        check("rst.req_valid", 64'(dmem_req_valid_o), 64'd0);
        check("rst.ready",     64'(ready_o), 64'd0);
        check("rst.lock",      64'(lock_o), 64'd0);
        check("rst.err",       64'(err_o), 64'd0);
        check("rst.data",      data_o, 64'd0);
        check("rst.addr",      dmem_req_addr_o, 64'd0);
        rstn_i = 1;
        step();

        // Load extension vectors.
        run_xact("lb",  0, 3'd0, 64'h1000, 5'd5, 64'h80, 64'hFFFF_FFFF_FFFF_FF80);
        run_xact("lbu", 0, 3'd4, 64'h1000, 5'd6, 64'h80, 64'h80);
        run_xact("lbp", 0, 3'd0, 64'h1001, 5'd7, 64'hAAAA_AAAA_AAAA_AA7F, 64'h7F);
        run_xact("lh",  0, 3'd1, 64'h1002, 5'd8, 64'h1234_5678_9ABC_8001, 64'hFFFF_FFFF_FFFF_8001);
        run_xact("lhu", 0, 3'd5, 64'h1002, 5'd9, 64'h1234_5678_9ABC_8001, 64'h8001);
        run_xact("lw",  0, 3'd2, 64'h1004, 5'd10, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_8000_0000);
        run_xact("lwu", 0, 3'd6, 64'h1004, 5'd11, 64'h1234_5678_8000_0000, 64'h8000_0000);
        run_xact("ld",  0, 3'd3, 64'h1008, 5'd12, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);

        // SD with the dcache busy for 3 cycles: request held for 4 cycles.
        start(1, 3'd3, 64'h2008, 64'hDEAD_BEEF, 5'd3, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_req_ready_i = 1;
            check("sd.req_valid", 64'(dmem_req_valid_o), 64'd1);
            check("sd.addr",      dmem_req_addr_o, 64'h2008);
            check("sd.wdata",     dmem_req_data_o, 64'hDEAD_BEEF);
            check("sd.cmd",       64'(dmem_req_cmd_o), 64'd1);
            #1 check("sd.lock",   64'(lock_o), 64'd1);
            step();
        end
        dmem_req_ready_i = 0;
        check("sd.wait_req_off", 64'(dmem_req_valid_o), 64'd0);
        dmem_resp_valid_i = 1; dmem_resp_data_i = 64'h5555;
        step();
        dmem_resp_valid_i = 0;
        check("sd.ready", 64'(ready_o), 64'd1);
        check("sd.data",  data_o, 64'd0);
        step();
        check("sd.ready_once", 64'(ready_o), 64'd0);

        // LW nacked twice, then answered.
        start(0, 3'd2, 64'h3000, 64'd0, 5'd4, 1);
        step();                                // WAIT
        for (int i = 0; i < 2; i++) begin
            dmem_resp_nack_i = 1;
            step();                            // back to REQ
            dmem_resp_nack_i = 0;
            check("lwn.reissue", 64'(dmem_req_valid_o), 64'd1);
            step();                            // WAIT
        end
        dmem_resp_valid_i = 1; dmem_resp_data_i = 64'h7FFF_FFFF;
        step();
        dmem_resp_valid_i = 0;
        check("lwn.ready", 64'(ready_o), 64'd1);
        check("lwn.data",  data_o, 64'h7FFF_FFFF);
        check("lwn.err",   64'(err_o), 64'd0);
        step();

        // Kill in WAIT with a simultaneous response.
        start(0, 3'd0, 64'h4000, 64'd0, 5'd13, 1);
        step();                                // WAIT
        kill_i = 1; dmem_resp_valid_i = 1; dmem_resp_data_i = 64'h55;
        #1 check("killw.kill_o", 64'(dmem_req_kill_o), 64'd1);
        step();
        kill_i = 0; dmem_resp_valid_i = 0;
        check("killw.ready", 64'(ready_o), 64'd0);
        check("killw.lock",  64'(lock_o), 64'd0);
        check("killw.idle",  64'(dmem_req_valid_o), 64'd0);
        check("killw.data",  data_o, 64'd0);
        step();
        check("killw.no_ready", 64'(ready_o), 64'd0);

        // Eret in REQ acts as a kill.
        start(0, 3'd3, 64'h4100, 64'd0, 5'd14, 0);
        csr_eret_i = 1;
        #1 check("eret.kill_o", 64'(dmem_req_kill_o), 64'd1);
        step();
        csr_eret_i = 0;
        check("eret.idle",  64'(dmem_req_valid_o), 64'd0);
        check("eret.ready", 64'(ready_o), 64'd0);

        // Kill in IDLE latches nothing.
        valid_i = 1; kill_i = 1; addr_i = 64'h9999; is_store_i = 0;
        step();
        valid_i = 0; kill_i = 0;
        check("killi.no_req", 64'(dmem_req_valid_o), 64'd0);
        check("killi.addr",   dmem_req_addr_o, 64'h4100);

        // Page fault and misaligned together: page fault wins, response ignored.
        start(0, 3'd3, 64'h5001, 64'd0, 5'd15, 1);
        step();
        dmem_xcpt_ma_ld_i = 1; dmem_xcpt_pf_ld_i = 1;
        dmem_resp_valid_i = 1; dmem_resp_data_i = 64'h1234;
        step();
        dmem_xcpt_ma_ld_i = 0; dmem_xcpt_pf_ld_i = 0; dmem_resp_valid_i = 0;
        check("pf.ready", 64'(ready_o), 64'd1);
        check("pf.xcpt",  64'(xcpt_o), 64'd2);
        check("pf.data",  data_o, 64'd0);
        step();

        // Misaligned store alone.
        start(1, 3'd3, 64'h5003, 64'h77, 5'd16, 1);
        step();
        dmem_xcpt_ma_st_i = 1;
        step();
        dmem_xcpt_ma_st_i = 0;
        check("ma.xcpt", 64'(xcpt_o), 64'd1);
        step();

        // Kill during DONE suppresses ready_o.
        start(0, 3'd3, 64'h6000, 64'd0, 5'd17, 1);
        step();
        dmem_resp_valid_i = 1; dmem_resp_data_i = 64'h42;
        step();
        dmem_resp_valid_i = 0; kill_i = 1;
        #1 check("killd.ready", 64'(ready_o), 64'd0);
        step();
        kill_i = 0;
        check("killd.idle_ready", 64'(ready_o), 64'd0);

        // valid_i held through DONE does not re-issue until IDLE.
        valid_i = 1; is_store_i = 0; funct3_i = 3'd3; addr_i = 64'h7000; rd_i = 5'd18;
        dmem_req_ready_i = 1;
        step();                                // REQ
        step();                                // WAIT
        dmem_resp_valid_i = 1; dmem_resp_data_i = 64'h99;
        step();                                // DONE
        dmem_resp_valid_i = 0;
        check("hold.ready", 64'(ready_o), 64'd1);
        step();                                // IDLE, valid_i still high
        check("hold.no_reissue", 64'(dmem_req_valid_o), 64'd0);
        check("hold.lock",       64'(lock_o), 64'd1);
        step();                                // new transaction in REQ
        check("hold.new_req", 64'(dmem_req_valid_o), 64'd1);
        valid_i = 0; kill_i = 1;
        step();
        kill_i = 0;

        // Sixteen consecutive nacks exceed the limit of 15 retries.
        start(0, 3'd3, 64'h8000, 64'd0, 5'd19, 1);
        step();                                // WAIT
        for (int i = 0; i < 16; i++) begin
            dmem_resp_nack_i = 1;
            step();
            dmem_resp_nack_i = 0;
            if (i < 15) begin
                check("nack16.retry", 64'(dmem_req_valid_o), 64'd1);
                check("nack16.err_lo", 64'(err_o), 64'd0);
                step();                        // WAIT
            end
        end
        check("nack16.ready", 64'(ready_o), 64'd1);
        check("nack16.err",   64'(err_o), 64'd1);
        check("nack16.xcpt",  64'(xcpt_o), 64'd0);
        step();
        check("nack16.sticky", 64'(err_o), 64'd1);

        // Reset while in WAIT; a late response is ignored.
        start(0, 3'd2, 64'hA000, 64'd0, 5'd20, 1);
        step();                                // WAIT
        rstn_i = 0;
        #1 check("rstw.no_kill", 64'(dmem_req_kill_o), 64'd0);
        step();
        check("rstw.err",   64'(err_o), 64'd0);
        check("rstw.addr",  dmem_req_addr_o, 64'd0);
        check("rstw.rd",    64'(rd_o), 64'd0);
        check("rstw.lock",  64'(lock_o), 64'd0);
        check("rstw.req",   64'(dmem_req_valid_o), 64'd0);
        rstn_i = 1;
        dmem_resp_valid_i = 1; dmem_resp_data_i = 64'hFFFF;
        step();
        dmem_resp_valid_i = 0;
        check("rstw.late_data", data_o, 64'd0);
        step();
        check("rstw.late_ready", 64'(ready_o), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
